// File: rtl/calc_pkg.sv
// ============================================================================
// Module : calc_pkg
// Brief  : Shared widths, MODE bit positions and FSM states for calc_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam int DEF_WIDTH = 6;
    localparam int DEF_OUT_W = 10;

    localparam int MODE_CMP = 0;
    localparam int MODE_SEL = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sum3_adder.sv
// ============================================================================
// Module : sum3_adder
// Brief  : Combinational three-input unsigned adder, WIDTH in, OUT_W out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sum3_adder #(
    parameter int WIDTH = 6,
    parameter int OUT_W = 10
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [OUT_W-1:0] o_sum
);

    assign o_sum = OUT_W'(i_a) + OUT_W'(i_b) + OUT_W'(i_c);

endmodule

`default_nettype wire

// File: rtl/calc_sequencer.sv
// ============================================================================
// Module : calc_sequencer
// Brief  : Job controller time-sharing one sum3_adder for group sum / min / max.
//          Compare modes and PASS2 exist only when CALC_SEQ_CMP_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] N0,
    input  logic [WIDTH-1:0] N1,
    input  logic [WIDTH-1:0] N2,
    input  logic [WIDTH-1:0] N3,
    input  logic [WIDTH-1:0] N4,
    input  logic [WIDTH-1:0] N5,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [OUT_W-1:0] OUT_N,
    output logic             BUSY
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a [3];
    logic [WIDTH-1:0] r_b [3];
    logic             r_sel;
    logic [OUT_W-1:0] r_out_n;
    logic             r_out_valid;
    logic             w_accept;
    logic             w_use_a;
    logic             w_cmp;
    logic [WIDTH-1:0] w_op0;
    logic [WIDTH-1:0] w_op1;
    logic [WIDTH-1:0] w_op2;
    logic [OUT_W-1:0] w_sum;

`ifdef CALC_SEQ_CMP_EN
    logic             r_cmp;
    logic [OUT_W-1:0] r_sa;
    logic [OUT_W-1:0] w_pick;

    assign w_cmp  = r_cmp;
    // PASS2 sees sum B on the adder while SA holds sum A
    assign w_pick = r_sel ? ((w_sum > r_sa) ? w_sum : r_sa)
                          : ((w_sum < r_sa) ? w_sum : r_sa);
`else
    logic w_unused_mode;

    assign w_cmp         = 1'b0;
    assign w_unused_mode = MODE[MODE_CMP];
`endif

    assign IN_READY  = (r_state == IDLE) && !RST;
    assign BUSY      = (r_state != IDLE);
    assign OUT_VALID = r_out_valid;
    assign OUT_N     = r_out_n;
    assign w_accept  = IN_VALID && IN_READY;

    // Compare jobs take group A first; single-pass jobs follow MODE_SEL
    assign w_use_a = (r_state == PASS1) ? (w_cmp || r_sel) :
                     (r_state == HOLD || r_state == IDLE) ? r_sel : 1'b0;

    assign w_op0 = w_use_a ? r_a[0] : r_b[0];
    assign w_op1 = w_use_a ? r_a[1] : r_b[1];
    assign w_op2 = w_use_a ? r_a[2] : r_b[2];

    sum3_adder #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) u_adder (
        .i_a   (w_op0),
        .i_b   (w_op1),
        .i_c   (w_op2),
        .o_sum (w_sum)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (IN_VALID) w_next = PASS1;
`ifdef CALC_SEQ_CMP_EN
            PASS1: w_next = w_cmp ? PASS2 : HOLD;
            PASS2: w_next = HOLD;
`else
            PASS1: w_next = HOLD;
`endif
            HOLD:  if (OUT_READY) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a         <= '{default: '0};
            r_b         <= '{default: '0};
            r_sel       <= 1'b0;
            r_out_n     <= '0;
            r_out_valid <= 1'b0;
`ifdef CALC_SEQ_CMP_EN
            r_cmp       <= 1'b0;
            r_sa        <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_a[0] <= N0;
                r_a[1] <= N1;
                r_a[2] <= N2;
                r_b[0] <= N3;
                r_b[1] <= N4;
                r_b[2] <= N5;
                r_sel  <= MODE[MODE_SEL];
`ifdef CALC_SEQ_CMP_EN
                r_cmp  <= MODE[MODE_CMP];
`endif
            end
            case (r_state)
                PASS1: begin
`ifdef CALC_SEQ_CMP_EN
                    if (w_cmp) begin
                        r_sa <= w_sum;
                    end else begin
                        r_out_n     <= w_sum;
                        r_out_valid <= 1'b1;
                    end
`else
                    r_out_n     <= w_sum;
                    r_out_valid <= 1'b1;
`endif
                end
`ifdef CALC_SEQ_CMP_EN
                PASS2: begin
                    r_out_n     <= w_pick;
                    r_out_valid <= 1'b1;
                end
`endif
                HOLD: begin
                    if (OUT_READY) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// ============================================================================
// Module : tb_calc_sequencer
// Brief  : Directed plus random jobs for calc_sequencer, checked against a
//          sum/min/max reference model. Honours CALC_SEQ_CMP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_calc_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       IN_VALID;
    logic       IN_READY;
    logic [1:0] MODE;
    logic [5:0] N0, N1, N2, N3, N4, N5;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [9:0] OUT_N;
    logic       BUSY;

    int n_pass  = 0;
    int n_total = 0;
    int cur [6];

    calc_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .MODE      (MODE),
        .N0        (N0),
        .N1        (N1),
        .N2        (N2),
        .N3        (N3),
        .N4        (N4),
        .N5        (N5),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_N     (OUT_N),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int model_result(input logic [1:0] m);
        int sa;
        int sb;
        sa = cur[0] + cur[1] + cur[2];
        sb = cur[3] + cur[4] + cur[5];
`ifdef CALC_SEQ_CMP_EN
        if (m[0]) return m[1] ? ((sa > sb) ? sa : sb) : ((sa < sb) ? sa : sb);
`endif
        return m[1] ? sa : sb;
    endfunction

    function automatic int model_latency(input logic [1:0] m);
`ifdef CALC_SEQ_CMP_EN
        if (m[0]) return 2;
`endif
        return 1;
    endfunction

    task automatic drive_ops();
        N0 = 6'(cur[0]); N1 = 6'(cur[1]); N2 = 6'(cur[2]);
        N3 = 6'(cur[3]); N4 = 6'(cur[4]); N5 = 6'(cur[5]);
    endtask

    task automatic scramble_ops();
        {N0, N1, N2} = 18'($urandom);
        {N3, N4, N5} = 18'($urandom);
    endtask

    // Offers one job, then checks latency, result, backpressure and release.
    task automatic run_job(input string tag, input logic [1:0] m, input int hold, input bit rdy_early);
        int waited;
        int lat;
        int exp_n;
        exp_n     = model_result(m);
        IN_VALID  = 1'b1;
        MODE      = m;
        drive_ops();
        OUT_READY = rdy_early;
        waited = 0;
        while (!IN_READY && waited < 20) begin
            @(posedge CLK); #1;
            waited++;
        end
        check({tag, " in_ready"}, 32'(IN_READY), 1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        MODE     = ~m;
        scramble_ops();
        lat = 0;
        while (!OUT_VALID && lat < 8) begin
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(model_latency(m)));
        check({tag, " out_n"}, 32'(OUT_N), 32'(exp_n));
        check({tag, " busy"}, 32'(BUSY), 1);
        check({tag, " in_ready_busy"}, 32'(IN_READY), 0);
        if (!rdy_early) begin
            for (int i = 0; i < hold; i++) begin
                IN_VALID = 1'b1;
                scramble_ops();
                @(posedge CLK); #1;
                check({tag, " hold_valid"}, 32'(OUT_VALID), 1);
                check({tag, " hold_n"}, 32'(OUT_N), 32'(exp_n));
                check({tag, " hold_in_ready"}, 32'(IN_READY), 0);
            end
            IN_VALID  = 1'b0;
            OUT_READY = 1'b1;
            @(posedge CLK); #1;
        end else begin
            @(posedge CLK); #1;
        end
        check({tag, " consumed"}, 32'(OUT_VALID), 0);
        check({tag, " ready_again"}, 32'(IN_READY), 1);
        OUT_READY = 1'b0;
    endtask

    initial begin
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        MODE      = 2'b00;
        N0 = '0; N1 = '0; N2 = '0; N3 = '0; N4 = '0; N5 = '0;
        #1;
        check("rst in_ready", 32'(IN_READY), 0);
        check("rst out_valid", 32'(OUT_VALID), 0);
        check("rst out_n", 32'(OUT_N), 0);
        check("rst busy", 32'(BUSY), 0);
        @(posedge CLK); @(posedge CLK); #3;
        RST = 1'b0;
        #1;
        check("post_rst in_ready", 32'(IN_READY), 1);

        cur = '{63, 63, 63, 0, 0, 0};
        run_job("max_a", 2'b10, 0, 1'b1);
        cur = '{50, 50, 50, 1, 2, 3};
        run_job("sum_b", 2'b00, 0, 1'b0);
        cur = '{10, 10, 10, 20, 20, 20};
        run_job("mode11", 2'b11, 0, 1'b1);
        run_job("mode01", 2'b01, 0, 1'b1);
        cur = '{15, 15, 15, 20, 20, 5};
        run_job("eq11", 2'b11, 0, 1'b0);
        run_job("eq01", 2'b01, 0, 1'b0);
        cur = '{7, 9, 11, 40, 41, 42};
        run_job("backpressure", 2'b01, 5, 1'b0);
        cur = '{10, 10, 10, 20, 20, 20};
        run_job("after_bp", 2'b11, 0, 1'b0);
        cur = '{10, 10, 10, 20, 20, 20};
        run_job("a30_b60", 2'b11, 0, 1'b1);

        for (int j = 0; j < 40; j++) begin
            for (int k = 0; k < 6; k++) cur[k] = int'($urandom_range(0, 63));
            run_job("rand", 2'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Abort a job mid-flight; the previous result in OUT_N is nonzero.
        cur = '{30, 30, 30, 40, 40, 40};
        IN_VALID  = 1'b1;
        MODE      = 2'b11;
        drive_ops();
        OUT_READY = 1'b0;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
`ifdef CALC_SEQ_CMP_EN
        @(posedge CLK); #1;
`endif
        RST = 1'b1;
        #1;
        check("abort out_valid", 32'(OUT_VALID), 0);
        check("abort out_n", 32'(OUT_N), 0);
        check("abort busy", 32'(BUSY), 0);
        check("abort in_ready", 32'(IN_READY), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check("abort no_result", 32'(OUT_VALID), 0);
            check("abort idle_ready", 32'(IN_READY), 1);
        end
        OUT_READY = 1'b0;

        cur = '{1, 2, 3, 4, 5, 6};
        run_job("post_abort", 2'b00, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
